// File: rtl/tlp_wr_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tlp_wr_axi_bridge
// Purpose  : Converts memory-write request TLPs (4DW header, up to 8 DW
//            payload) into single-beat AXI4 write transactions (AW, W, B).
//            One transaction in flight at a time. Malformed or oversized
//            TLPs are consumed, dropped and counted in drop_cnt.
// Ports    : clk, rst_n (synchronous, active-low)
//            in_*      : TLP input (data, hdr, sop, eop, valid / ready)
//            m_axi_aw* : AXI write address channel (single beat, INCR)
//            m_axi_w*  : AXI write data channel (wlast always 1)
//            m_axi_b*  : AXI write response channel
//            drop_cnt  : saturating count of dropped TLPs
//            err_cnt   : saturating count of non-OKAY write responses
// Options  : TLP_WR_BRESP_CHK_EN - when defined, err_cnt counts non-OKAY
//            BRESPs; otherwise err_cnt is constant 0 and bresp is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module tlp_wr_axi_bridge #(
    parameter int DOUBLE_WORD  = 32,
    parameter int HEADER_SIZE  = 4*DOUBLE_WORD,
    parameter int PAYLOAD_SIZE = 8*DOUBLE_WORD,
    parameter int ADDR_W       = 64,
    parameter int CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PAYLOAD_SIZE-1:0]   in_data,
    input  logic [HEADER_SIZE-1:0]    in_hdr,
    input  logic                      in_sop,
    input  logic                      in_eop,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [ADDR_W-1:0]         m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [PAYLOAD_SIZE-1:0]   m_axi_wdata,
    output logic [PAYLOAD_SIZE/8-1:0] m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic [CNT_W-1:0]          err_cnt
);

    localparam int C_LANES = PAYLOAD_SIZE / DOUBLE_WORD;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        XFER = 3'b010,
        RESP = 3'b100
    } state_t;

    state_t r_state;

    // Header field decode
    logic [7:0]  w_fmt_type;
    logic [9:0]  w_len;
    logic [3:0]  w_first_be;
    logic [3:0]  w_last_be;
    logic [2:0]  w_off;
    logic [10:0] w_end;
    logic        w_legal;

    assign w_fmt_type = in_hdr[127:120];
    assign w_len      = in_hdr[105:96];
    assign w_first_be = in_hdr[67:64];
    assign w_last_be  = in_hdr[71:68];
    assign w_off      = in_hdr[4:2];
    // One past the last DW lane touched; 11 bits so a large len cannot wrap
    assign w_end      = {8'b0, w_off} + {1'b0, w_len};

    assign w_legal = (w_fmt_type == 8'b011_00000) && in_sop && in_eop &&
                     (w_len != 10'd0) && (w_len <= 10'd8) && (w_end <= 11'd8);

    // Payload placed at its DW offset inside the 32-byte AXI beat
    logic [PAYLOAD_SIZE-1:0]   w_shift;
    logic [PAYLOAD_SIZE-1:0]   w_wdata;
    logic [PAYLOAD_SIZE/8-1:0] w_wstrb;

    assign w_shift = in_data << {w_off, 5'b0};

    always_comb begin
        w_wdata = '0;
        w_wstrb = '0;
        for (int i = 0; i < C_LANES; i++) begin
            if ((11'(i) >= {8'b0, w_off}) && (11'(i) < w_end)) begin
                w_wdata[DOUBLE_WORD*i +: DOUBLE_WORD] = w_shift[DOUBLE_WORD*i +: DOUBLE_WORD];
                // First lane takes priority so a single-DW write ignores last_be
                if (11'(i) == {8'b0, w_off})
                    w_wstrb[4*i +: 4] = w_first_be;
                else if (11'(i) == w_end - 11'd1)
                    w_wstrb[4*i +: 4] = w_last_be;
                else
                    w_wstrb[4*i +: 4] = 4'hF;
            end
        end
    end

    // Header bits that carry nothing this bridge uses
    logic w_unused_hdr;
    assign w_unused_hdr = ^{in_hdr[119:106], in_hdr[95:72], in_hdr[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            in_ready      <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awlen   <= '0;
            m_axi_awsize  <= '0;
            m_axi_awburst <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wlast   <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            drop_cnt      <= '0;
`ifdef TLP_WR_BRESP_CHK_EN
            err_cnt       <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (w_legal) begin
                            m_axi_awaddr  <= {in_hdr[63:32], in_hdr[31:5], 5'b0};
                            m_axi_awlen   <= 8'd0;
                            m_axi_awsize  <= 3'b101;
                            m_axi_awburst <= 2'b01;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wdata   <= w_wdata;
                            m_axi_wstrb   <= w_wstrb;
                            m_axi_wlast   <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            in_ready      <= 1'b0;
                            r_state       <= XFER;
                        end else if (drop_cnt != {CNT_W{1'b1}}) begin
                            drop_cnt <= drop_cnt + C_CNT_ONE;
                        end
                    end
                end
                XFER: begin
                    if (m_axi_awvalid && m_axi_awready)
                        m_axi_awvalid <= 1'b0;
                    if (m_axi_wvalid && m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                        m_axi_wlast  <= 1'b0;
                    end
                    // Each channel is done if already retired or handshaking now
                    if ((!m_axi_awvalid || m_axi_awready) &&
                        (!m_axi_wvalid  || m_axi_wready)) begin
                        m_axi_bready <= 1'b1;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        in_ready     <= 1'b1;
                        r_state      <= IDLE;
`ifdef TLP_WR_BRESP_CHK_EN
                        if ((m_axi_bresp != 2'b00) && (err_cnt != {CNT_W{1'b1}}))
                            err_cnt <= err_cnt + C_CNT_ONE;
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifndef TLP_WR_BRESP_CHK_EN
    logic w_unused_bresp;
    assign w_unused_bresp = ^m_axi_bresp;
    assign err_cnt        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tlp_wr_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlp_wr_axi_bridge
// Purpose  : Self-checking bench for tlp_wr_axi_bridge. A vector table of
//            TLPs with hand-computed AXI results, plus directed sequences
//            for delayed handshakes, error responses and mid-flight reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlp_wr_axi_bridge;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] in_data;
    logic [127:0] in_hdr;
    logic         in_sop, in_eop, in_valid, in_ready;
    logic [63:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic [2:0]   m_axi_awsize;
    logic [1:0]   m_axi_awburst;
    logic         m_axi_awvalid, m_axi_awready;
    logic [255:0] m_axi_wdata;
    logic [31:0]  m_axi_wstrb;
    logic         m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]   m_axi_bresp;
    logic         m_axi_bvalid, m_axi_bready;
    logic [15:0]  drop_cnt, err_cnt;

    always #5 clk = ~clk;

    tlp_wr_axi_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_hdr(in_hdr), .in_sop(in_sop), .in_eop(in_eop),
        .in_valid(in_valid), .in_ready(in_ready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    typedef struct {
        logic [7:0]   fmt;
        logic [9:0]   len;
        logic [3:0]   fbe;
        logic [3:0]   lbe;
        logic [63:0]  addr;
        logic         sop;
        logic         eop;
        logic [255:0] data;
        logic         legal;
        logic [63:0]  exp_awaddr;
        logic [31:0]  exp_wstrb;
        logic [255:0] exp_wdata;
        logic [15:0]  exp_drop;
    } vec_t;

    localparam logic [255:0] DA = {32'hA0000007, 32'hA0000006, 32'hA0000005, 32'hA0000004,
                                   32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
    localparam logic [255:0] D0 = {32'hA0000007, 32'hA0000006, 32'hA0000005, 32'hA0000004,
                                   32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hDEADBEEF};
    localparam logic [255:0] W0 = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
    localparam logic [255:0] W2 = {32'h0, 32'h0, 32'h0, 32'h0,
                                   32'hA0000002, 32'hA0000001, 32'hA0000000, 32'h0};
    localparam logic [255:0] W3 = {32'hA0000001, 32'hA0000000, 32'h0, 32'h0,
                                   32'h0, 32'h0, 32'h0, 32'h0};
    localparam logic [255:0] W4 = {32'hA0000000, 32'h0, 32'h0, 32'h0,
                                   32'h0, 32'h0, 32'h0, 32'h0};

    localparam int NV = 10;
    vec_t vecs [NV];

    int tests  = 0;
    int failed = 0;
    int aw_hs  = 0;
    int w_hs   = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (m_axi_awvalid && m_axi_awready) aw_hs = aw_hs + 1;
            if (m_axi_wvalid && m_axi_wready)   w_hs  = w_hs + 1;
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_hdr(input logic [7:0] fmt, input logic [9:0] len,
                                            input logic [3:0] fbe, input logic [3:0] lbe,
                                            input logic [63:0] addr);
        logic [127:0] h;
        h          = '0;
        h[127:120] = fmt;
        h[105:96]  = len;
        h[71:68]   = lbe;
        h[67:64]   = fbe;
        h[63:0]    = addr;
        return h;
    endfunction

    // Wait (bounded) for in_ready, present one TLP for a single accept cycle
    task automatic send(input vec_t v);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        in_hdr   = mk_hdr(v.fmt, v.len, v.fbe, v.lbe, v.addr);
        in_data  = v.data;
        in_sop   = v.sop;
        in_eop   = v.eop;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    int aw0, w0;

    initial begin
        vecs[0] = '{8'h60, 10'd1, 4'hF, 4'h3, 64'h0000_0001_0000_0008, 1'b1, 1'b1, D0,
                    1'b1, 64'h0000_0001_0000_0000, 32'h0000_0F00, W0, 16'd0};
        vecs[1] = '{8'h60, 10'd8, 4'h1, 4'h8, 64'h0000_0000_0000_2000, 1'b1, 1'b1, DA,
                    1'b1, 64'h0000_0000_0000_2000, 32'h8FFF_FFF1, DA, 16'd0};
        vecs[2] = '{8'h60, 10'd3, 4'hE, 4'h7, 64'h0000_0000_0000_0044, 1'b1, 1'b1, DA,
                    1'b1, 64'h0000_0000_0000_0040, 32'h0000_7FE0, W2, 16'd0};
        vecs[3] = '{8'h60, 10'd2, 4'hC, 4'h3, 64'h0000_0000_0000_0018, 1'b1, 1'b1, DA,
                    1'b1, 64'h0000_0000_0000_0000, 32'h3C00_0000, W3, 16'd0};
        vecs[4] = '{8'h60, 10'd1, 4'h9, 4'h5, 64'h0000_0000_0000_001C, 1'b1, 1'b1, DA,
                    1'b1, 64'h0000_0000_0000_0000, 32'h9000_0000, W4, 16'd0};
        vecs[5] = '{8'h40, 10'd1, 4'hF, 4'h0, 64'h0000_0000_0000_0000, 1'b1, 1'b1, DA,
                    1'b0, 64'h0, 32'h0, 256'h0, 16'd1};
        vecs[6] = '{8'h60, 10'd0, 4'hF, 4'hF, 64'h0000_0000_0000_0000, 1'b1, 1'b1, DA,
                    1'b0, 64'h0, 32'h0, 256'h0, 16'd2};
        vecs[7] = '{8'h60, 10'd3, 4'hF, 4'hF, 64'h0000_0000_0000_0018, 1'b1, 1'b1, DA,
                    1'b0, 64'h0, 32'h0, 256'h0, 16'd3};
        vecs[8] = '{8'h60, 10'd1, 4'hF, 4'h0, 64'h0000_0000_0000_0000, 1'b0, 1'b1, DA,
                    1'b0, 64'h0, 32'h0, 256'h0, 16'd4};
        vecs[9] = '{8'h60, 10'd9, 4'hF, 4'hF, 64'h0000_0000_0000_0000, 1'b1, 1'b1, DA,
                    1'b0, 64'h0, 32'h0, 256'h0, 16'd5};

        rst_n = 1'b0; in_data = '0; in_hdr = '0; in_sop = 1'b0; in_eop = 1'b0;
        in_valid = 1'b0; m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        m_axi_bresp = 2'b00; m_axi_bvalid = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_awvalid", m_axi_awvalid, 0);
        chk("rst_bready", m_axi_bready, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Table: immediate readies, B returned as soon as bready rises
        for (int i = 0; i < NV; i++) begin
            aw0 = aw_hs;
            send(vecs[i]);
            if (vecs[i].legal) begin
                chk($sformatf("v%0d_awvalid", i), m_axi_awvalid, 1);
                chk($sformatf("v%0d_wvalid", i), m_axi_wvalid, 1);
                chk($sformatf("v%0d_wlast", i), m_axi_wlast, 1);
                chk($sformatf("v%0d_in_ready_lo", i), in_ready, 0);
                chk($sformatf("v%0d_awaddr", i), m_axi_awaddr, vecs[i].exp_awaddr);
                chk($sformatf("v%0d_wstrb", i), m_axi_wstrb, vecs[i].exp_wstrb);
                chk($sformatf("v%0d_wdata", i), m_axi_wdata, vecs[i].exp_wdata);
                chk($sformatf("v%0d_awattr", i), {m_axi_awlen, m_axi_awsize, m_axi_awburst},
                    {8'd0, 3'b101, 2'b01});
                @(posedge clk); #1;
                chk($sformatf("v%0d_bready", i), m_axi_bready, 1);
                chk($sformatf("v%0d_valids_lo", i), {m_axi_awvalid, m_axi_wvalid, in_ready}, 0);
                @(posedge clk); #1;
                chk($sformatf("v%0d_ready_back", i), {in_ready, m_axi_bready}, 2'b10);
            end else begin
                chk($sformatf("v%0d_drop_ready", i), in_ready, 1);
                chk($sformatf("v%0d_no_aw", i), m_axi_awvalid, 0);
                @(posedge clk); #1;
                chk($sformatf("v%0d_no_aw2", i), {m_axi_awvalid, m_axi_wvalid}, 0);
                chk($sformatf("v%0d_aw_hs", i), aw_hs - aw0, 0);
            end
            chk($sformatf("v%0d_drop_cnt", i), drop_cnt, vecs[i].exp_drop);
        end

        // AW delayed 4 cycles, W immediate
        aw0 = aw_hs; w0 = w_hs;
        m_axi_awready = 1'b0;
        send(vecs[2]);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("awdly_hold", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b100);
            chk("awdly_addr_stable", m_axi_awaddr, 64'h40);
        end
        m_axi_awready = 1'b1;
        @(posedge clk); #1;
        chk("awdly_bready", {m_axi_awvalid, m_axi_bready}, 2'b01);
        @(posedge clk); #1;
        chk("awdly_done", in_ready, 1);
        chk("awdly_hs", {16'(aw_hs - aw0), 16'(w_hs - w0)}, {16'd1, 16'd1});

        // W delayed 4 cycles, AW immediate
        aw0 = aw_hs; w0 = w_hs;
        m_axi_wready = 1'b0;
        send(vecs[3]);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("wdly_hold", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b010);
            chk("wdly_data_stable", m_axi_wdata, W3);
        end
        m_axi_wready = 1'b1;
        @(posedge clk); #1;
        chk("wdly_bready", {m_axi_wvalid, m_axi_bready}, 2'b01);
        @(posedge clk); #1;
        chk("wdly_done", in_ready, 1);
        chk("wdly_hs", {16'(aw_hs - aw0), 16'(w_hs - w0)}, {16'd1, 16'd1});

        // SLVERR response
        m_axi_bresp = 2'b10;
        send(vecs[1]);
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_axi_bresp = 2'b00;
`ifdef TLP_WR_BRESP_CHK_EN
        chk("err_cnt", err_cnt, 1);
`else
        chk("err_cnt", err_cnt, 0);
`endif

        // Reset while AW/W are pending
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        send(vecs[0]);
        chk("xfer_awvalid", m_axi_awvalid, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ctrl", {in_ready, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready}, 0);
        chk("midrst_cnt", {drop_cnt, err_cnt}, 0);
        chk("midrst_payload", {m_axi_awaddr, m_axi_wstrb, m_axi_awsize, m_axi_awburst}, 0);
        chk("midrst_wdata", m_axi_wdata, 0);
        rst_n = 1'b1;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready", in_ready, 1);
        send(vecs[0]);
        chk("after_rst_awaddr", m_axi_awaddr, 64'h0000_0001_0000_0000);
        chk("after_rst_wstrb", m_axi_wstrb, 32'h0000_0F00);
        @(posedge clk); #1;
        chk("after_rst_bready", m_axi_bready, 1);
        @(posedge clk); #1;
        chk("after_rst_done", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
